// File: rtl/choreo_sequencer.sv
// choreo_sequencer: steps the LED pattern generator through a programmed playlist on beat ticks.
// Optional CHOREO_PINGPONG_EN: a looping playlist bounces between its endpoints instead of wrapping.
module choreo_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DUR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DUR_W+3:0]  wr_data,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic              loop_en,
    input  logic              beat,
    output logic [2:0]        pat_sel,
    output logic              speed_sel,
    output logic              pause,
    output logic [ADDR_W-1:0] step_idx,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef struct packed {
        logic [DUR_W-1:0] dur;
        logic             speed;
        logic [2:0]       pat;
    } entry_t;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DONE} state_t;

    state_t            state;
    entry_t            mem [DEPTH];
    entry_t            rd_q;
    logic [LEN_W-1:0]  len;
    logic [DUR_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] next_idx;
    logic [ADDR_W-1:0] load_idx;
    logic              last_pass;
    logic              start_ok;
    logic              wr_ok;
    logic              step_end;

    assign wr_ok    = wr_en && (state == IDLE);
    assign start_ok = start && (seq_len != '0) && (seq_len <= LEN_W'(DEPTH));
    assign step_end = (state == RUN) && !hold && beat && (beat_cnt == DUR_W'(1));
    // Address the entry that the next LOAD will consume, so its data is ready during LOAD.
    assign load_idx = (state == RUN) ? next_idx : '0;

`ifdef CHOREO_PINGPONG_EN
    logic back;
    logic next_back;

    // Successor entry when bouncing; endpoints are not replayed on a turnaround.
    always_comb begin
        next_idx  = '0;
        next_back = back;
        last_pass = 1'b0;
        if (!back) begin
            if (LEN_W'(step_idx) + LEN_W'(1) < len) begin
                next_idx = step_idx + ADDR_W'(1);
            end else if (!loop_en) begin
                last_pass = 1'b1;
            end else if (len != LEN_W'(1)) begin
                next_back = 1'b1;
                next_idx  = ADDR_W'(len - LEN_W'(2));
            end
        end else begin
            if (step_idx != '0) begin
                next_idx = step_idx - ADDR_W'(1);
            end else if (!loop_en) begin
                last_pass = 1'b1;
            end else begin
                next_back = 1'b0;
                next_idx  = ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back <= 1'b0;
        end else if (stop || (state == IDLE)) begin
            back <= 1'b0;
        end else if (step_end && !last_pass) begin
            back <= next_back;
        end
    end
`else
    // Successor entry when wrapping back to entry 0.
    always_comb begin
        next_idx  = '0;
        last_pass = 1'b0;
        if (LEN_W'(step_idx) + LEN_W'(1) < len) begin
            next_idx = step_idx + ADDR_W'(1);
        end else if (!loop_en) begin
            last_pass = 1'b1;
        end
    end
`endif

    // Playlist storage with a registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= entry_t'(wr_data);
        end
        rd_q <= mem[load_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat_sel   <= 3'b111;
            speed_sel <= 1'b0;
            pause     <= 1'b0;
            step_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_err    <= 1'b0;
            len       <= '0;
            beat_cnt  <= '0;
        end else begin
            wr_err <= wr_en && (state != IDLE);
            done   <= 1'b0;
            if (stop || (state == DONE)) begin
                state     <= IDLE;
                pat_sel   <= 3'b111;
                speed_sel <= 1'b0;
                pause     <= 1'b0;
                step_idx  <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state    <= LOAD;
                            step_idx <= '0;
                            len      <= seq_len;
                            busy     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        pat_sel   <= rd_q.pat;
                        speed_sel <= rd_q.speed;
                        beat_cnt  <= (rd_q.dur == '0) ? DUR_W'(1) : rd_q.dur;
                        state     <= RUN;
                    end
                    RUN: begin
                        if (hold) begin
                            state <= HOLD;
                            pause <= 1'b1;
                        end else if (beat) begin
                            if (beat_cnt != DUR_W'(1)) begin
                                beat_cnt <= beat_cnt - DUR_W'(1);
                            end else if (last_pass) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= LOAD;
                                step_idx <= next_idx;
                            end
                        end
                    end
                    HOLD: begin
                        if (!hold) begin
                            state <= RUN;
                            pause <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_choreo_sequencer.sv
// Bench for choreo_sequencer: behavioural playlist model compared every cycle, plus literal step checks.
module tb_choreo_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 6;
    localparam int EW    = DW + 4;

    typedef int arr10_t [10];

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [EW-1:0] wr_data = '0;
    logic [AW:0]   seq_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          hold = 1'b0;
    logic          loop_en = 1'b0;
    logic          beat = 1'b0;
    logic [2:0]    pat_sel;
    logic          speed_sel;
    logic          pause;
    logic [AW-1:0] step_idx;
    logic          busy;
    logic          done;
    logic          wr_err;

    int n_vec = 0;
    int n_err = 0;

    choreo_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .DUR_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .seq_len(seq_len), .start(start), .stop(stop), .hold(hold), .loop_en(loop_en),
        .beat(beat), .pat_sel(pat_sel), .speed_sel(speed_sel), .pause(pause),
        .step_idx(step_idx), .busy(busy), .done(done), .wr_err(wr_err)
    );

    initial forever #5 clk = ~clk;

    // Behavioural model: where the sequencer is in the playlist and what the generator should see.
    logic [EW-1:0] m_mem [DEPTH];
    bit            m_busy, m_gap, m_frozen, m_done, m_werr, m_spd, m_back;
    logic [2:0]    m_pat;
    logic [AW-1:0] m_idx;
    int            m_left, m_len;

    task automatic m_to_idle();
        m_busy = 0; m_gap = 0; m_frozen = 0; m_done = 0;
        m_pat = 3'b111; m_spd = 0; m_idx = '0; m_back = 0;
    endtask

    task automatic m_step();
        bit idle_now, fin;
        int nxt, d;
        if (!rst_n) begin
            m_to_idle();
            m_werr = 0; m_left = 0; m_len = 0;
            return;
        end
        idle_now = !m_busy && !m_done;
        m_werr = wr_en && !idle_now;
        if (wr_en && idle_now) m_mem[wr_addr] = wr_data;
        if (stop || m_done) begin
            m_to_idle();
        end else if (idle_now) begin
            if (start && seq_len >= 1 && seq_len <= DEPTH) begin
                m_busy = 1; m_gap = 1; m_idx = '0; m_len = int'(seq_len); m_back = 0;
            end
        end else if (m_gap) begin
            d = int'(m_mem[m_idx][EW-1:4]);
            m_left = (d == 0) ? 1 : d;
            m_pat = m_mem[m_idx][2:0];
            m_spd = m_mem[m_idx][3];
            m_gap = 0;
        end else if (m_frozen) begin
            if (!hold) m_frozen = 0;
        end else if (hold) begin
            m_frozen = 1;
        end else if (beat) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                fin = 0;
                nxt = 0;
`ifdef CHOREO_PINGPONG_EN
                if (!m_back) begin
                    if (m_idx + 1 < m_len) nxt = m_idx + 1;
                    else if (!loop_en) fin = 1;
                    else if (m_len == 1) nxt = 0;
                    else begin m_back = 1; nxt = m_len - 2; end
                end else begin
                    if (m_idx > 0) nxt = m_idx - 1;
                    else if (!loop_en) fin = 1;
                    else begin m_back = 0; nxt = 1; end
                end
`else
                if (m_idx + 1 < m_len) nxt = m_idx + 1;
                else if (loop_en) nxt = 0;
                else fin = 1;
`endif
                if (fin) begin m_busy = 0; m_done = 1; end
                else begin m_idx = AW'(nxt); m_gap = 1; end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        m_step();
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        logic [11:0] act, want;
        @(negedge clk);
        act  = {pat_sel, speed_sel, pause, step_idx, busy, done, wr_err};
        want = {m_pat, m_spd, m_frozen, m_idx, m_busy, m_done, m_werr};
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL outputs t=%0t got pat=%b spd=%b pause=%b idx=%0d busy=%b done=%b werr=%b, expected pat=%b spd=%b pause=%b idx=%0d busy=%b done=%b werr=%b",
                     $time, pat_sel, speed_sel, pause, step_idx, busy, done, wr_err,
                     m_pat, m_spd, m_frozen, m_idx, m_busy, m_done, m_werr);
        end
    end

    int idx_log[$];
    int pat_log[$];
    int n_done, n_werr;

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic clear_logs();
        idx_log.delete(); pat_log.delete(); n_done = 0; n_werr = 0;
    endtask

    task automatic tick(input bit b);
        @(negedge clk);
        if (done === 1'b1) n_done++;
        if (wr_err === 1'b1) n_werr++;
        if (b) begin idx_log.push_back(int'(step_idx)); pat_log.push_back(int'(pat_sel)); end
        beat = b;
    endtask

    task automatic beats(input int n);
        repeat (n) begin tick(1); tick(0); tick(0); tick(0); end
    endtask

    task automatic go(input int len, input bit lp);
        @(negedge clk);
        seq_len = (AW+1)'(len); loop_en = lp; start = 1; beat = 0;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wr(input int a, input logic [EW-1:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic do_stop();
        @(negedge clk); stop = 1;
        @(negedge clk); stop = 0;
    endtask

    task automatic chk_log(input string tag, input bit use_pat, input arr10_t want, input int n);
        chk({tag, "_count"}, idx_log.size(), n);
        for (int i = 0; i < n && i < idx_log.size(); i++)
            chk($sformatf("%s_%0d", tag, i), use_pat ? pat_log[i] : idx_log[i], want[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected end earlier", $time);
        $fatal(1);
    end

    initial begin
        arr10_t w;
        #1 rst_n = 0;
        #3;
        chk("rst_pat", int'(pat_sel), 7);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(step_idx), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) wr(i, {DW'($urandom_range(0, 3)), 4'($urandom)});

        // Two-step playlist plays through once then pulses done.
        wr(0, 10'h020);
        wr(1, 10'h03D);
        clear_logs();
        go(2, 0);
        beats(5);
        w = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0}; chk_log("t1_idx", 0, w, 5);
        w = '{0, 0, 5, 5, 5, 0, 0, 0, 0, 0}; chk_log("t1_pat", 1, w, 5);
        chk("t1_done", n_done, 1);
        chk("t1_pat_after", int'(pat_sel), 7);
        chk("t1_busy_after", int'(busy), 0);

        // Looping playback never finishes.
        clear_logs();
        go(2, 1);
        beats(10);
        w = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1}; chk_log("t2_idx", 0, w, 10);
        chk("t2_done", n_done, 0);
        do_stop();

        // Hold freezes step 1 with two beats left; they still play after release.
        clear_logs();
        go(2, 0);
        beats(3);
        hold = 1;
        beats(5);
        chk("t3_pause", int'(pause), 1);
        chk("t3_idx", int'(step_idx), 1);
        chk("t3_done_hold", n_done, 0);
        hold = 0;
        tick(0); tick(0);
        clear_logs();
        beats(1);
        chk("t3_done_early", n_done, 0);
        beats(1);
        chk("t3_done_end", n_done, 1);

        // Writes while busy are rejected; invalid lengths do not start.
        clear_logs();
        go(2, 0);
        beats(1);
        wr(1, 10'h3F7);
        chk("t4_werr", int'(wr_err), 1);
        tick(0);
        chk("t4_werr_once", int'(wr_err), 0);
        do_stop();
        clear_logs();
        go(2, 0);
        beats(5);
        w = '{0, 0, 5, 5, 5, 0, 0, 0, 0, 0}; chk_log("t4_pat", 1, w, 5);
        go(0, 0);
        tick(0); tick(0);
        chk("t4_len0_busy", int'(busy), 0);
        go(17, 0);
        tick(0); tick(0);
        chk("t4_len17_busy", int'(busy), 0);

        // Stop beats a step-ending beat; start with stop in idle stays idle.
        clear_logs();
        go(2, 0);
        beats(4);
        @(negedge clk); beat = 1; stop = 1;
        @(negedge clk); beat = 0; stop = 0;
        chk("t5_nodone", int'(done), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_pat", int'(pat_sel), 7);
        tick(0); tick(0);
        chk("t5_nodone_later", n_done, 0);
        @(negedge clk); seq_len = 2; start = 1; stop = 1;
        @(negedge clk); start = 0; stop = 0;
        tick(0);
        chk("t5_startstop_busy", int'(busy), 0);

        // Three single-beat steps looping; then a zero-duration entry.
        wr(0, 10'h011); wr(1, 10'h012); wr(2, 10'h013);
        clear_logs();
        go(3, 1);
        beats(7);
`ifdef CHOREO_PINGPONG_EN
        w = '{0, 1, 2, 1, 0, 1, 2, 0, 0, 0};
`else
        w = '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0};
`endif
        chk_log("t6_idx", 0, w, 7);
        do_stop();
        wr(0, 10'h004);
        clear_logs();
        go(1, 0);
        beats(1);
        chk("t6_dur0_done", n_done, 1);
        chk("t6_dur0_pat", pat_log.size() > 0 ? pat_log[0] : -1, 4);

        // Asynchronous reset mid-run keeps the playlist.
        wr(0, 10'h020); wr(1, 10'h03D);
        go(2, 1);
        beats(3);
        #2 rst_n = 0;
        #1;
        chk("t7_rst_busy", int'(busy), 0);
        chk("t7_rst_pat", int'(pat_sel), 7);
        chk("t7_rst_idx", int'(step_idx), 0);
        @(negedge clk); rst_n = 1;
        clear_logs();
        go(2, 0);
        beats(5);
        w = '{0, 0, 5, 5, 5, 0, 0, 0, 0, 0}; chk_log("t7_pat", 1, w, 5);
        chk("t7_done", n_done, 1);

        // Random traffic against the model.
        for (int i = 0; i < DEPTH; i++) wr(i, {DW'($urandom_range(0, 3)), 4'($urandom)});
        repeat (4000) begin
            @(negedge clk);
            beat    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            stop    = ($urandom_range(0, 79) == 0);
            start   = ($urandom_range(0, 7) == 0);
            seq_len = (AW+1)'($urandom_range(0, 17));
            loop_en = 1'($urandom_range(0, 1));
            wr_en   = !start && ($urandom_range(0, 9) == 0);
            wr_addr = AW'($urandom);
            wr_data = {DW'($urandom_range(0, 3)), 4'($urandom)};
        end
        @(negedge clk);
        beat = 0; hold = 0; start = 0; wr_en = 0; stop = 1;
        @(negedge clk); stop = 0;
        tick(0);
        chk("end_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
